// File: rtl/instr_fetch_queue_if.sv
// Fetch-side bus between the program counter / program loader (master) and
// instr_fetch_queue (slave).
//   req_valid/req_ready/req_addr : fetch request channel (byte address)
//   flush                        : discard all queued and in-flight fetches
//   rsp_valid/rsp_ready          : response channel handshake
//   rsp_instr/rsp_pc/rsp_fault   : head entry of the response queue
//   wr_en/wr_addr/wr_data        : program-load write port (word index)
interface instr_fetch_queue_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        flush;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_instr;
  logic [31:0] rsp_pc;
  logic        rsp_fault;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;

  modport master (
    output req_valid, req_addr, flush, rsp_ready, wr_en, wr_addr, wr_data,
    input  req_ready, rsp_valid, rsp_instr, rsp_pc, rsp_fault
  );

  modport slave (
    input  req_valid, req_addr, flush, rsp_ready, wr_en, wr_addr, wr_data,
    output req_ready, rsp_valid, rsp_instr, rsp_pc, rsp_fault
  );
endinterface

// File: rtl/instr_fetch_queue.sv
// Instruction fetch responder: accepts fetch addresses, reads a synchronous
// word-addressed instruction memory and returns {instr, pc, fault} in request
// order through a small circular response queue.
//   clk   : single clock, rising edge
//   reset : synchronous, active-high; memory contents are preserved
//   bus   : instr_fetch_queue_if.slave (request, response, flush, write port)
// Parameters: DEPTH_WORDS (memory words, power of two), QDEPTH (queue entries,
// power of two, >= 2).
module instr_fetch_queue #(
  parameter int DEPTH_WORDS = 1024,
  parameter int QDEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  instr_fetch_queue_if.slave    bus
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;

  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] rdata_q;

  logic [31:0] q_instr [QDEPTH];
  logic [31:0] q_pc    [QDEPTH];
  logic        q_fault [QDEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          inflight_q, inflight_d;
  logic [31:0]   pc_q, pc_d;
  logic          fault_q, fault_d;

  logic          req_fault;
  logic          req_ready;
  logic          accept;
  logic          push;
  logic          pop;
  logic          wr_in_range;
  logic [CW-1:0] occupancy;
  logic [31:0]   push_instr;

  always_comb begin
    req_fault   = (bus.req_addr[1:0] != 2'b00) ||
                  (bus.req_addr[31:2] >= 30'(DEPTH_WORDS));
    wr_in_range = bus.wr_addr < 32'(DEPTH_WORDS);
    // The in-flight fetch already owns a queue slot, so it counts toward
    // occupancy; a same-cycle pop does not open a slot until the next cycle.
    occupancy   = count_q + CW'(inflight_q);
    req_ready   = !bus.flush && (occupancy < CW'(QDEPTH));
    accept      = bus.req_valid && req_ready;
    push        = inflight_q && !bus.flush;
    pop         = (count_q != '0) && bus.rsp_ready && !bus.flush;
    // Faulted fetches never read memory; their slot carries a NOP.
    push_instr  = fault_q ? 32'h0000_0000 : rdata_q;
  end

  always_comb begin
    inflight_d = accept;
    pc_d       = accept ? bus.req_addr : pc_q;
    fault_d    = accept ? req_fault    : fault_q;
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    if (bus.flush) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      count_d = count_q + CW'(push) - CW'(pop);
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      inflight_q <= 1'b0;
      pc_q       <= '0;
      fault_q    <= 1'b0;
    end else begin
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      inflight_q <= inflight_d;
      pc_q       <= pc_d;
      fault_q    <= fault_d;
    end
  end

  // Memory is never cleared. Non-blocking read and write on the same edge
  // give read-first behaviour for a collision on the same word.
  always_ff @(posedge clk) begin
    if (!reset && accept && !req_fault) rdata_q <= mem[bus.req_addr[AW+1:2]];
    if (!reset && bus.wr_en && wr_in_range) mem[bus.wr_addr[AW-1:0]] <= bus.wr_data;
  end

  // Queue payload needs no reset: it is only visible while count_q != 0.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      q_instr[wr_ptr_q] <= push_instr;
      q_pc[wr_ptr_q]    <= pc_q;
      q_fault[wr_ptr_q] <= fault_q;
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = count_q != '0;
  assign bus.rsp_instr = bus.rsp_valid ? q_instr[rd_ptr_q] : 32'h0;
  assign bus.rsp_pc    = bus.rsp_valid ? q_pc[rd_ptr_q]    : 32'h0;
  assign bus.rsp_fault = bus.rsp_valid ? q_fault[rd_ptr_q] : 1'b0;
endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue: inputs change 1 time unit after the
// rising edge, outputs are sampled on the falling edge.
module tb_instr_fetch_queue;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  instr_fetch_queue_if bus ();

  instr_fetch_queue #(.DEPTH_WORDS(1024), .QDEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input int idx, input logic [31:0] data);
    bus.wr_en   = 1'b1;
    bus.wr_addr = 32'(idx);
    bus.wr_data = data;
    tick();
    bus.wr_en   = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_valid got %0h want 0", bus.rsp_valid); end
    n_cmp++; if (bus.rsp_instr !== 32'h0) begin n_bad++; $display("FAIL reset_rsp_instr got %h want 0", bus.rsp_instr); end
    n_cmp++; if (bus.rsp_pc !== 32'h0) begin n_bad++; $display("FAIL reset_rsp_pc got %h want 0", bus.rsp_pc); end
    n_cmp++; if (bus.rsp_fault !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_fault got %0h want 0", bus.rsp_fault); end
    n_cmp++; if (bus.req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_req_ready got %0h want 1", bus.req_ready); end
    tick();
  endtask

  task automatic test_sequential();
    logic exp_v;
    for (int i = 0; i < 8; i++) load_word(i, 32'h2000_0000 + 32'(i));
    for (int k = 0; k < 12; k++) begin
      bus.req_valid = (k < 8);
      bus.req_addr  = 32'(4 * k);
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      exp_v = (k >= 2) && (k <= 9);
      n_cmp++; if (bus.rsp_valid !== exp_v) begin n_bad++; $display("FAIL seq_valid cyc %0d got %0h want %0h", k, bus.rsp_valid, exp_v); end
      if (exp_v) begin
        n_cmp++; if (bus.rsp_instr !== 32'h2000_0000 + 32'(k - 2)) begin n_bad++; $display("FAIL seq_instr cyc %0d got %h want %h", k, bus.rsp_instr, 32'h2000_0000 + 32'(k - 2)); end
        n_cmp++; if (bus.rsp_pc !== 32'(4 * (k - 2))) begin n_bad++; $display("FAIL seq_pc cyc %0d got %h want %h", k, bus.rsp_pc, 32'(4 * (k - 2))); end
        n_cmp++; if (bus.rsp_fault !== 1'b0) begin n_bad++; $display("FAIL seq_fault cyc %0d got %0h want 0", k, bus.rsp_fault); end
      end
      if (k < 8) begin
        n_cmp++; if (bus.req_ready !== 1'b1) begin n_bad++; $display("FAIL seq_req_ready cyc %0d got %0h want 1", k, bus.req_ready); end
      end
      tick();
    end
    bus.req_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    int accepts = 0;
    bus.rsp_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      bus.req_valid = 1'b1;
      bus.req_addr  = 32'(4 * accepts);
      @(negedge clk);
      n_cmp++; if (bus.req_ready !== (k < 4)) begin n_bad++; $display("FAIL bp_req_ready cyc %0d got %0h want %0h", k, bus.req_ready, (k < 4)); end
      if (bus.req_ready === 1'b1) accepts++;
      tick();
    end
    n_cmp++; if (accepts != 4) begin n_bad++; $display("FAIL bp_accepts got %0d want 4", accepts); end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    for (int k = 6; k < 11; k++) begin
      @(negedge clk);
      n_cmp++; if (bus.rsp_valid !== (k < 10)) begin n_bad++; $display("FAIL bp_drain_valid cyc %0d got %0h want %0h", k, bus.rsp_valid, (k < 10)); end
      if (k < 10) begin
        n_cmp++; if (bus.rsp_pc !== 32'(4 * (k - 6))) begin n_bad++; $display("FAIL bp_drain_pc cyc %0d got %h want %h", k, bus.rsp_pc, 32'(4 * (k - 6))); end
        n_cmp++; if (bus.rsp_instr !== 32'h2000_0000 + 32'(k - 6)) begin n_bad++; $display("FAIL bp_drain_instr cyc %0d got %h want %h", k, bus.rsp_instr, 32'h2000_0000 + 32'(k - 6)); end
      end
      if (k <= 7) begin
        n_cmp++; if (bus.req_ready !== (k == 7)) begin n_bad++; $display("FAIL bp_reassert cyc %0d got %0h want %0h", k, bus.req_ready, (k == 7)); end
      end
      tick();
    end
  endtask

  task automatic test_faults();
    logic [31:0] addrs  [3] = '{32'h0000_0002, 32'h0000_0008, 32'h0000_1000};
    logic [31:0] exp_i  [3] = '{32'h0, 32'h2000_0002, 32'h0};
    logic        exp_f  [3] = '{1'b1, 1'b0, 1'b1};
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      bus.req_valid = (k < 3);
      bus.req_addr  = (k < 3) ? addrs[k] : 32'h0;
      @(negedge clk);
      n_cmp++; if (bus.rsp_valid !== (k >= 2 && k <= 4)) begin n_bad++; $display("FAIL flt_valid cyc %0d got %0h", k, bus.rsp_valid); end
      if (k >= 2 && k <= 4) begin
        n_cmp++; if (bus.rsp_fault !== exp_f[k-2]) begin n_bad++; $display("FAIL flt_fault cyc %0d got %0h want %0h", k, bus.rsp_fault, exp_f[k-2]); end
        n_cmp++; if (bus.rsp_instr !== exp_i[k-2]) begin n_bad++; $display("FAIL flt_instr cyc %0d got %h want %h", k, bus.rsp_instr, exp_i[k-2]); end
        n_cmp++; if (bus.rsp_pc !== addrs[k-2]) begin n_bad++; $display("FAIL flt_pc cyc %0d got %h want %h", k, bus.rsp_pc, addrs[k-2]); end
      end
      tick();
    end
  endtask

  task automatic test_flush();
    load_word(16, 32'hC0DE_0010);
    bus.rsp_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bus.req_valid = 1'b1;
      bus.req_addr  = 32'(4 * k);
      tick();
    end
    bus.flush     = 1'b1;
    bus.rsp_ready = 1'b1;
    bus.req_addr  = 32'h40;
    @(negedge clk);
    n_cmp++; if (bus.req_ready !== 1'b0) begin n_bad++; $display("FAIL fl_req_ready_in_flush got %0h want 0", bus.req_ready); end
    n_cmp++; if (bus.rsp_valid !== 1'b1) begin n_bad++; $display("FAIL fl_head_before got %0h want 1", bus.rsp_valid); end
    tick();
    bus.flush = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_bad++; $display("FAIL fl_valid_after got %0h want 0", bus.rsp_valid); end
    n_cmp++; if (bus.req_ready !== 1'b1) begin n_bad++; $display("FAIL fl_req_ready_after got %0h want 1", bus.req_ready); end
    tick();
    bus.req_valid = 1'b0;
    for (int k = 6; k < 10; k++) begin
      @(negedge clk);
      n_cmp++; if (bus.rsp_valid !== (k == 7)) begin n_bad++; $display("FAIL fl_rsp_valid cyc %0d got %0h want %0h", k, bus.rsp_valid, (k == 7)); end
      if (k == 7) begin
        n_cmp++; if (bus.rsp_instr !== 32'hC0DE_0010) begin n_bad++; $display("FAIL fl_instr got %h want c0de0010", bus.rsp_instr); end
        n_cmp++; if (bus.rsp_pc !== 32'h40) begin n_bad++; $display("FAIL fl_pc got %h want 40", bus.rsp_pc); end
      end
      tick();
    end
  endtask

  task automatic test_collision();
    load_word(5, 32'hAAAA_0000);
    bus.rsp_ready = 1'b1;
    bus.wr_en     = 1'b1;
    bus.wr_addr   = 32'd5;
    bus.wr_data   = 32'h5555_FFFF;
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h14;
    @(negedge clk);
    n_cmp++; if (bus.req_ready !== 1'b1) begin n_bad++; $display("FAIL col_req_ready got %0h want 1", bus.req_ready); end
    tick();
    bus.wr_en     = 1'b0;
    bus.req_valid = 1'b0;
    tick();
    @(negedge clk);
    n_cmp++; if (bus.rsp_instr !== 32'hAAAA_0000) begin n_bad++; $display("FAIL col_old_data got %h want aaaa0000", bus.rsp_instr); end
    tick();
    bus.wr_en     = 1'b1;
    bus.wr_addr   = 32'd1024;
    bus.wr_data   = 32'hDEAD_BEEF;
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h14;
    tick();
    bus.wr_en     = 1'b0;
    bus.req_addr  = 32'h0;
    tick();
    bus.req_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.rsp_instr !== 32'h5555_FFFF) begin n_bad++; $display("FAIL col_new_data got %h want 5555ffff", bus.rsp_instr); end
    tick();
    @(negedge clk);
    n_cmp++; if (bus.rsp_instr !== 32'h2000_0000) begin n_bad++; $display("FAIL col_oor_write got %h want 20000000", bus.rsp_instr); end
    n_cmp++; if (bus.rsp_pc !== 32'h0) begin n_bad++; $display("FAIL col_oor_pc got %h want 0", bus.rsp_pc); end
    tick();
  endtask

  task automatic test_reset_mid();
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h0;
    tick();
    bus.req_addr  = 32'h4;
    tick();
    bus.req_valid = 1'b0;
    tick();
    reset         = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h8;
    bus.wr_en     = 1'b1;
    bus.wr_addr   = 32'd0;
    bus.wr_data   = 32'hBAD0_BAD0;
    @(negedge clk);
    n_cmp++; if (bus.rsp_valid !== 1'b1) begin n_bad++; $display("FAIL rm_valid_before got %0h want 1", bus.rsp_valid); end
    tick();
    reset         = 1'b0;
    bus.req_valid = 1'b0;
    bus.wr_en     = 1'b0;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rm_valid got %0h want 0", bus.rsp_valid); end
    n_cmp++; if (bus.rsp_instr !== 32'h0) begin n_bad++; $display("FAIL rm_instr got %h want 0", bus.rsp_instr); end
    n_cmp++; if (bus.rsp_pc !== 32'h0) begin n_bad++; $display("FAIL rm_pc got %h want 0", bus.rsp_pc); end
    n_cmp++; if (bus.rsp_fault !== 1'b0) begin n_bad++; $display("FAIL rm_fault got %0h want 0", bus.rsp_fault); end
    n_cmp++; if (bus.req_ready !== 1'b1) begin n_bad++; $display("FAIL rm_req_ready got %0h want 1", bus.req_ready); end
    for (int k = 0; k < 2; k++) begin
      tick();
      @(negedge clk);
      n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rm_no_stale cyc %0d got %0h want 0", k, bus.rsp_valid); end
    end
    tick();
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h0;
    tick();
    bus.req_valid = 1'b0;
    tick();
    @(negedge clk);
    n_cmp++; if (bus.rsp_instr !== 32'h2000_0000) begin n_bad++; $display("FAIL rm_write_blocked got %h want 20000000", bus.rsp_instr); end
    tick();
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_addr  = 32'h0;
    bus.flush     = 1'b0;
    bus.rsp_ready = 1'b0;
    bus.wr_en     = 1'b0;
    bus.wr_addr   = 32'h0;
    bus.wr_data   = 32'h0;
    test_reset();
    test_sequential();
    test_backpressure();
    test_faults();
    test_flush();
    test_collision();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
